// File: rtl/lm_sm_sequencer.sv
// lm_sm_sequencer: expands LM/SM/LA/SA into ascending single-register micro-ops with dense word offsets
module lm_sm_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  input  logic        stall_in,
  input  logic        flush,
  output logic        hold_fetch,
  output logic        busy,
  output logic        uop_valid,
  output logic        uop_is_load,
  output logic [2:0]  k_reg,
  output logic [2:0]  addr_off,
  output logic        uop_first,
  output logic        uop_last
);
  typedef enum logic {IDLE, SEQ} state_t;
  state_t      state_q, state_d;
  logic [7:0]  pend_q, pend_d;
  logic [2:0]  cnt_q, cnt_d, k_q, k_d, off_q, off_d;
  logic        load_q, load_d, valid_q, valid_d, first_q, first_d, last_q, last_d;
  logic [7:0]  mask, rest;
  logic        accept;
  function automatic logic [2:0] lowest(input logic [7:0] m);
    lowest = 3'd0;
    for (int i = 7; i >= 0; i--) if (m[i]) lowest = i[2:0];
  endfunction
  function automatic logic single(input logic [7:0] m);
    return (m & (m - 8'd1)) == 8'd0;
  endfunction
  assign mask   = instr[13] ? 8'hFF : instr[7:0];
  assign accept = state_q == IDLE && instr_valid && instr[15:14] == 2'b11 && |mask && !flush;
  assign rest   = pend_q & (pend_q - 8'd1);
  // state, pending mask and micro-op registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      cnt_q   <= '0;
      k_q     <= '0;
      off_q   <= '0;
      load_q  <= 1'b0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      off_q   <= off_d;
      load_q  <= load_d;
      valid_q <= valid_d;
      first_q <= first_d;
      last_q  <= last_d;
    end
  end
  // next state: flush wins, stall freezes, train ends when no bits remain after the issued one
  always_comb begin
    state_d = flush ? IDLE : stall_in ? state_q : state_q == IDLE ? (accept ? SEQ : IDLE) : (|rest ? SEQ : IDLE);
  end
  // micro-op datapath: accept latches the mask, each unstalled SEQ edge retires the lowest pending bit
  always_comb begin
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    off_d   = off_q;
    load_d  = load_q;
    valid_d = valid_q;
    first_d = first_q;
    last_d  = last_q;
    if (flush) begin
      pend_d  = '0;
      cnt_d   = '0;
      valid_d = 1'b0;
      first_d = 1'b0;
      last_d  = 1'b0;
    end else if (!stall_in && state_q == IDLE && accept) begin
      pend_d  = mask;
      cnt_d   = '0;
      k_d     = lowest(mask);
      off_d   = '0;
      load_d  = ~instr[12];
      valid_d = 1'b1;
      first_d = 1'b1;
      last_d  = single(mask);
    end else if (!stall_in && state_q == SEQ) begin
      pend_d  = rest;
      cnt_d   = cnt_q + 3'd1;
      k_d     = |rest ? lowest(rest) : k_q;
      off_d   = |rest ? cnt_q + 3'd1 : off_q;
      valid_d = |rest;
      first_d = 1'b0;
      last_d  = |rest && single(rest);
    end
  end
  // fetch hold and status outputs
  always_comb begin
    busy       = state_q == SEQ;
    hold_fetch = flush ? 1'b0 : state_q == IDLE ? accept : !last_q;
  end
  assign uop_valid   = valid_q;
  assign uop_is_load = load_q;
  assign k_reg       = k_q;
  assign addr_off    = off_q;
  assign uop_first   = first_q;
  assign uop_last    = last_q;
endmodule

// File: tb/tb_lm_sm_sequencer.sv
// tb_lm_sm_sequencer: random and directed stimulus checked against a queue-based micro-op model
module tb_lm_sm_sequencer;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] instr;
  logic        instr_valid, stall_in, flush;
  logic        hold_fetch, busy, uop_valid, uop_is_load, uop_first, uop_last;
  logic [2:0]  k_reg, addr_off;
  int          nvec = 0;
  int          nerr = 0;
  typedef struct {int k; int off;} uop_t;
  uop_t train[$];
  logic m_load;
  lm_sm_sequencer dut (
    .clk(clk), .reset_n(reset_n), .instr(instr), .instr_valid(instr_valid),
    .stall_in(stall_in), .flush(flush), .hold_fetch(hold_fetch), .busy(busy),
    .uop_valid(uop_valid), .uop_is_load(uop_is_load), .k_reg(k_reg),
    .addr_off(addr_off), .uop_first(uop_first), .uop_last(uop_last)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [7:0] mmask(input logic [15:0] i);
    case (i[15:12])
      4'hC, 4'hD: return i[7:0];
      4'hE, 4'hF: return 8'hFF;
      default:    return 8'h00;
    endcase
  endfunction
  function automatic logic exp_hold();
    if (flush) return 1'b0;
    if (train.size() == 0) return instr_valid && mmask(instr) != 0;
    return train.size() > 1;
  endfunction
  task automatic model_edge();
    int n;
    logic [7:0] m;
    if (flush) train.delete();
    else if (stall_in) ;
    else if (train.size() > 0) void'(train.pop_front());
    else if (instr_valid && mmask(instr) != 0) begin
      m = mmask(instr);
      n = 0;
      for (int r = 0; r < 8; r++) if (m[r]) begin
        train.push_back('{k: r, off: n});
        n++;
      end
      m_load = instr[12] == 1'b0;
    end
  endtask
  task automatic check_outs(input string ctx);
    chk({ctx, " uop_valid"}, uop_valid, train.size() > 0);
    chk({ctx, " busy"}, busy, train.size() > 0);
    if (train.size() > 0) begin
      chk({ctx, " k_reg"}, k_reg, train[0].k[7:0]);
      chk({ctx, " addr_off"}, addr_off, train[0].off[7:0]);
      chk({ctx, " uop_first"}, uop_first, train[0].off == 0);
      chk({ctx, " uop_last"}, uop_last, train.size() == 1);
      chk({ctx, " uop_is_load"}, uop_is_load, m_load);
    end
  endtask
  task automatic step(input string ctx, input logic [15:0] ins, input logic iv, input logic st, input logic fl);
    instr = ins;
    instr_valid = iv;
    stall_in = st;
    flush = fl;
    #1 chk({ctx, " hold_fetch"}, hold_fetch, exp_hold());
    @(posedge clk);
    model_edge();
    #1 check_outs(ctx);
  endtask
  task automatic check_zero(input string ctx);
    chk({ctx, " uop_valid"}, uop_valid, 8'd0);
    chk({ctx, " busy"}, busy, 8'd0);
    chk({ctx, " uop_is_load"}, uop_is_load, 8'd0);
    chk({ctx, " k_reg"}, k_reg, 8'd0);
    chk({ctx, " addr_off"}, addr_off, 8'd0);
    chk({ctx, " uop_first"}, uop_first, 8'd0);
    chk({ctx, " uop_last"}, uop_last, 8'd0);
    chk({ctx, " hold_fetch"}, hold_fetch, 8'd0);
  endtask
  initial begin
    logic [15:0] ri;
    int op;
    reset_n = 1'b0;
    instr = 16'h0000;
    instr_valid = 1'b0;
    stall_in = 1'b0;
    flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    step("lm_a5", 16'b1100_010_0_1010_0101, 1, 0, 0);
    repeat (4) step("lm_a5", 16'h0000, 1, 0, 0);
    step("sa", 16'hF000, 1, 0, 0);
    repeat (2) step("sa", 16'h0000, 1, 0, 0);
    repeat (2) step("sa_stall", 16'h0000, 1, 1, 0);
    repeat (6) step("sa", 16'h0000, 1, 0, 0);
    step("lm_zero", 16'hC200, 1, 0, 0);
    step("add", 16'h0123, 1, 0, 0);
    step("lm_80", 16'hC080, 1, 0, 0);
    step("lm_80", 16'h0000, 1, 0, 0);
    step("la", 16'hE000, 1, 0, 0);
    repeat (2) step("la", 16'h0000, 1, 0, 0);
    step("la_flush", 16'h0000, 1, 0, 1);
    step("sm_after_flush", 16'hD00C, 1, 0, 0);
    repeat (3) step("sm_after_flush", 16'h0000, 1, 0, 0);
    step("lm_ff", 16'hC0FF, 1, 0, 0);
    repeat (3) step("lm_ff", 16'h0000, 1, 0, 0);
    #2 reset_n = 1'b0;
    instr_valid = 1'b0;
    #1 check_zero("midreset");
    train.delete();
    @(negedge clk);
    reset_n = 1'b1;
    step("lm_post_reset", 16'hC036, 1, 0, 0);
    repeat (4) step("lm_post_reset", 16'h0000, 1, 0, 0);
    for (int c = 0; c < 600; c++) begin
      op = $urandom_range(0, 7);
      ri = 16'($urandom);
      if (op < 4) ri[15:12] = 4'hC + 4'(op);
      if ($urandom_range(0, 4) == 0) ri[7:0] = 8'h00;
      step("rand", ri, $urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/lm_sm_sequencer.md
# lm_sm_sequencer

Multi-register load/store sequencer for the 5-stage pipeline. It sits in the decode stage and expands one LM, SM, LA or SA instruction into a train of single-register micro-ops. Each micro-op carries a register index `k_reg` (consumed by the MEM-stage destination block as `k_mem`) and a word offset from the base register RA. While the train is issued, it stalls fetch/decode.

## Interface

- No parameters. The ISA field positions are fixed.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `instr`  in  16  instruction currently held in the IF/ID register.
- `instr_valid`  in  1  `instr` is a live (non-bubble) instruction.
- `stall_in`  in  1  downstream stall; freezes the sequencer and all outputs.
- `flush`  in  1  branch/jump flush of ID; aborts any train in progress.
- `hold_fetch`  out  1  holds PC and IF/ID; combinational.
- `busy`  out  1  state is SEQ.
- `uop_valid`  out  1  registered; a micro-op is presented this cycle.
- `uop_is_load`  out  1  registered; 1 for LM/LA, 0 for SM/SA.
- `k_reg`  out  3  registered; register index of the micro-op.
- `addr_off`  out  3  registered; word offset added to RA for this micro-op.
- `uop_first`  out  1  registered; first micro-op of the train.
- `uop_last`  out  1  registered; last micro-op of the train.

## Operation

- Decode on `instr[15:12]`:
  - LM = 1100, SM = 1101: mask = `instr[7:0]`.
  - LA = 1110, SA = 1111: mask = 8'hFF.
  - Any other opcode is not multi.
- Mask bit i selects register Ri.
- FSM states: IDLE, SEQ.
- IDLE → SEQ at the clock edge where all of the following hold:
  - `instr_valid` is 1,
  - the opcode is multi,
  - mask != 0,
  - `stall_in` = 0,
  - `flush` = 0.
- On that edge the sequencer:
  - latches `pend` = mask, the load/store flag, and `cnt` = 0;
  - drives the first micro-op onto the outputs (lowest set bit of mask, `addr_off` = 0, `uop_first` = 1).
- In SEQ, on each edge with `stall_in` = 0:
  - clear the bit just issued from `pend`;
  - `cnt` += 1;
  - if `pend` is still nonzero, present the next lowest set bit with `addr_off` = `cnt`;
  - otherwise go to IDLE and drive `uop_valid` = 0.
- Order is strictly ascending register index. Offsets are dense (0, 1, 2, …), so memory words are consecutive.
- `uop_last` = 1 when the presented bit is the only remaining bit of `pend`.
- `instr` is ignored while in SEQ.
- Zero mask (LM/SM with `instr[7:0]` = 0): no transition, no micro-op, `hold_fetch` = 0. The instruction retires as a NOP.
- `hold_fetch` = 1 in either case:
  - IDLE with an accepting multi instruction (mask != 0, `flush` = 0), or
  - SEQ with the presented micro-op not last.
  - Otherwise `hold_fetch` = 0.
- `flush`, any state: at the next edge go to IDLE and clear `uop_valid`, `uop_first` and `uop_last`. `flush` overrides `stall_in`. While `flush` = 1, `hold_fetch` = 0.
- `stall_in` = 1: state, `pend`, `cnt` and all registered outputs hold. `hold_fetch` keeps its combinational value.
- Reset (asynchronous, any time, including mid-train):
  - state IDLE, `pend` = 0, `cnt` = 0;
  - `uop_valid`, `uop_is_load`, `uop_first`, `uop_last`, `busy` = 0;
  - `k_reg` = 0, `addr_off` = 0.

## Timing

- Acceptance edge E0: the first micro-op is visible in the cycle after E0.
- A train of N set bits presents its micro-ops in cycles 1..N after E0 (no stalls). Each stalled cycle adds one cycle.
- `hold_fetch` is high from the acceptance cycle through cycle N−1 and low in cycle N. IF/ID therefore advances at the edge ending cycle N, and a new instruction is in ID at cycle N+1.
- A back-to-back multi instruction is accepted in cycle N+1; there is no dead cycle beyond the refetch.
- LA/SA always take 8 micro-op cycles, with `addr_off` running 0..7.
- `addr_off` never exceeds 7; `cnt` is 3 bits and cannot wrap within a train.

## Test plan

- **LM, 16'b1100_010_0_1010_0101:** micro-ops k = 0, 2, 5, 7 with `addr_off` = 0, 1, 2, 3 on four consecutive cycles. `uop_is_load` = 1. `uop_first` on k = 0, `uop_last` on k = 7. `hold_fetch` low in the 4th cycle.
- **SA with `stall_in` high for 2 cycles after the 3rd micro-op:** 8 micro-ops, k = 0..7 with `addr_off` = k. Outputs frozen at k = 2 for 2 extra cycles. `uop_is_load` = 0. Total 10 cycles.
- **LM with mask 8'h00, then ADD:** no `uop_valid`, `hold_fetch` never high, `busy` stays 0.
- **Single-bit mask 8'h80:** one micro-op, k = 7, `addr_off` = 0, `uop_first` = `uop_last` = 1. `hold_fetch` high only in the acceptance cycle.
- **LA with `flush` asserted during the 3rd micro-op:** `uop_valid` = 0 on the next cycle, state IDLE, next `instr` decoded normally.
- **`reset_n` dropped mid-train (between edges):** all outputs go to 0 immediately. After release, the FSM is idle and accepts a new LM.
